// File: rtl/cpu_exec_unit_if.sv
// Operand/control bundle between the decoder/register file and the execute stage.
// The master drives the instruction fields; the slave returns controls and results.
interface cpu_exec_unit_if;
   logic [3:0] opcode;
   logic [2:0] func;
   logic       ready;
   logic [7:0] ra;
   logic [7:0] rb;
   logic [7:0] imm;

   logic       reg_dst;
   logic       reg_write;
   logic       apb_op;
   logic       apb_write;
   logic       continue_flag;
   logic       nia;
   logic       br;
   logic [7:0] aluout;
   logic [7:0] wb_data;

   modport master (
      output opcode, func, ready, ra, rb, imm,
      input  reg_dst, reg_write, apb_op, apb_write, continue_flag, nia, br, aluout, wb_data
   );

   modport slave (
      input  opcode, func, ready, ra, rb, imm,
      output reg_dst, reg_write, apb_op, apb_write, continue_flag, nia, br, aluout, wb_data
   );
endinterface

// File: rtl/cpu_exec_unit.sv
// Execute/memory stage of bit_cpu: opcode decode, 8-bit ALU, 256x8 data memory,
// write-back select and branch/jump/APB-stall indications for the PC logic.
module cpu_exec_unit (
   input logic             clk,
   input logic             rst_n,
   cpu_exec_unit_if.slave  bus
);

   localparam logic [3:0] OpRtype = 4'h0;
   localparam logic [3:0] OpAddi  = 4'h1;
   localparam logic [3:0] OpAndi  = 4'h2;
   localparam logic [3:0] OpOri   = 4'h3;
   localparam logic [3:0] OpLoad  = 4'h4;
   localparam logic [3:0] OpStore = 4'h5;
   localparam logic [3:0] OpBeq   = 4'h6;
   localparam logic [3:0] OpBne   = 4'h7;
   localparam logic [3:0] OpJump  = 4'h8;
   localparam logic [3:0] OpApbWr = 4'h9;
   localparam logic [3:0] OpApbRd = 4'hA;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluXor = 3'b100;
   localparam logic [2:0] AluSll = 3'b101;
   localparam logic [2:0] AluSrl = 3'b110;
   localparam logic [2:0] AluSne = 3'b111;

   logic [2:0] alufn;
   logic       alusrc;
   logic       mem_read;
   logic       mem_write;
   logic       mem_to_reg;
   logic       branch_eq;
   logic       branch_ne;
   logic       reg_dst;
   logic       reg_write;
   logic       apb_op;
   logic       apb_write;
   logic       nia;
   logic       continue_flag;

   logic [7:0] operand;
   logic [7:0] alu_res;
   logic [7:0] aluout;
   logic [7:0] mem_rdata;
   logic [7:0] mem_q [256];

   always_comb begin
      alufn         = AluAdd;
      alusrc        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      branch_eq     = 1'b0;
      branch_ne     = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      apb_op        = 1'b0;
      apb_write     = 1'b0;
      nia           = 1'b1;
      continue_flag = 1'b1;
      case (bus.opcode)
         OpRtype: begin
            alufn      = bus.func;
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         OpAddi, OpAndi, OpOri: begin
            alufn      = (bus.opcode == OpAddi) ? AluAdd :
                         (bus.opcode == OpAndi) ? AluAnd : AluOr;
            alusrc     = 1'b1;
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         OpLoad: begin
            alusrc    = 1'b1;
            mem_read  = 1'b1;
            reg_write = 1'b1;
         end
         OpStore: begin
            alusrc    = 1'b1;
            mem_write = 1'b1;
         end
         OpBeq: begin
            alufn     = AluSub;
            branch_eq = 1'b1;
         end
         OpBne: begin
            alufn     = AluSne;
            branch_ne = 1'b1;
         end
         OpJump: nia = 1'b0;
         OpApbWr: begin
            apb_op        = 1'b1;
            apb_write     = 1'b1;
            continue_flag = bus.ready;
         end
         OpApbRd: begin
            apb_op        = 1'b1;
            reg_write     = bus.ready;
            continue_flag = bus.ready;
         end
         default: ;
      endcase
   end

   assign operand = alusrc ? bus.imm : bus.rb;

   always_comb begin
      alu_res = 8'h00;
      case (alufn)
         AluAdd: alu_res = bus.ra + operand;
         AluSub: alu_res = bus.ra - operand;
         AluAnd: alu_res = bus.ra & operand;
         AluOr:  alu_res = bus.ra | operand;
         AluXor: alu_res = bus.ra ^ operand;
         AluSll: alu_res = bus.ra << operand[2:0];
         AluSrl: alu_res = bus.ra >> operand[2:0];
         AluSne: alu_res = {7'b0, bus.ra != operand};
         default: alu_res = 8'h00;
      endcase
   end

   // APB transfers use no address from the ALU, so the bus shows a clean zero.
   assign aluout = apb_op ? 8'h00 : alu_res;

   // Reset wipes the whole array at once; loads issued during reset therefore see 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (mem_write) begin
         mem_q[aluout] <= bus.rb;
      end
   end

   assign mem_rdata = mem_read ? mem_q[aluout] : 8'h00;

   assign bus.reg_dst       = reg_dst;
   assign bus.reg_write     = reg_write;
   assign bus.apb_op        = apb_op;
   assign bus.apb_write     = apb_write;
   assign bus.continue_flag = continue_flag;
   assign bus.nia           = nia;
   assign bus.br            = (branch_eq && (alu_res == 8'h00)) ||
                              (branch_ne && (alu_res == 8'h01));
   assign bus.aluout        = aluout;
   assign bus.wb_data       = mem_to_reg ? aluout : mem_rdata;

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Scoreboard bench for cpu_exec_unit: driver pushes model predictions, monitor compares
// them against the DUT outputs each time a new instruction has settled.
module tb_cpu_exec_unit;

   typedef struct packed {
      logic [7:0] aluout;
      logic [7:0] wb_data;
      logic       reg_dst;
      logic       reg_write;
      logic       apb_op;
      logic       apb_write;
      logic       continue_flag;
      logic       nia;
      logic       br;
   } exp_t;

   logic clk;
   logic rst_n;

   cpu_exec_unit_if bus ();

   cpu_exec_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] ref_mem [256];
   exp_t       exp_q [$];
   string      tag_q [$];
   event       vec_ev;
   int         vectors     = 0;
   int         miscompares = 0;

   logic       pend_we   = 1'b0;
   logic [7:0] pend_addr = 8'h00;
   logic [7:0] pend_data = 8'h00;

   // Reference semantics written instruction by instruction.
   function automatic exp_t model(input logic [3:0] op, input logic [2:0] fn,
                                  input logic rdy, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] im);
      exp_t e;
      e = '0;
      e.nia = 1'b1;
      e.continue_flag = 1'b1;
      e.aluout = a + b;
      case (op)
         4'h0: begin
            case (fn)
               3'd0: e.aluout = a + b;
               3'd1: e.aluout = a - b;
               3'd2: e.aluout = a & b;
               3'd3: e.aluout = a | b;
               3'd4: e.aluout = a ^ b;
               3'd5: e.aluout = 8'((16'(a) * (16'd1 << b[2:0])) & 16'hFF);
               3'd6: e.aluout = 8'(a / (8'd1 << b[2:0]));
               default: e.aluout = (a == b) ? 8'd0 : 8'd1;
            endcase
            e.reg_dst = 1'b1;
            e.reg_write = 1'b1;
            e.wb_data = e.aluout;
         end
         4'h1: begin e.aluout = a + im; e.reg_write = 1'b1; e.wb_data = e.aluout; end
         4'h2: begin e.aluout = a & im; e.reg_write = 1'b1; e.wb_data = e.aluout; end
         4'h3: begin e.aluout = a | im; e.reg_write = 1'b1; e.wb_data = e.aluout; end
         4'h4: begin e.aluout = a + im; e.reg_write = 1'b1; e.wb_data = ref_mem[e.aluout]; end
         4'h5: e.aluout = a + im;
         4'h6: begin e.aluout = a - b; e.br = (a == b); end
         4'h7: begin e.aluout = (a != b) ? 8'd1 : 8'd0; e.br = (a != b); end
         4'h8: e.nia = 1'b0;
         4'h9: begin
            e.aluout = 8'h00; e.apb_op = 1'b1; e.apb_write = 1'b1; e.continue_flag = rdy;
         end
         4'hA: begin
            e.aluout = 8'h00; e.apb_op = 1'b1; e.reg_write = rdy; e.continue_flag = rdy;
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic apply(input string tag, input logic [3:0] op, input logic [2:0] fn,
                        input logic rdy, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] im);
      @(posedge clk);
      if (pend_we && rst_n) ref_mem[pend_addr] = pend_data;
      pend_we = 1'b0;
      #1;
      bus.opcode = op;
      bus.func   = fn;
      bus.ready  = rdy;
      bus.ra     = a;
      bus.rb     = b;
      bus.imm    = im;
      #1;
      exp_q.push_back(model(op, fn, rdy, a, b, im));
      tag_q.push_back(tag);
      if (op == 4'h5) begin
         pend_we   = 1'b1;
         pend_addr = a + im;
         pend_data = b;
      end
      -> vec_ev;
   endtask

   task automatic set_rst(input logic v);
      rst_n = v;
      if (!v) foreach (ref_mem[i]) ref_mem[i] = 8'h00;
   endtask

   // Pulse between edges; a store still held on the bus lands at the following edge.
   task automatic pulse_rst();
      set_rst(1'b0);
      #2;
      set_rst(1'b1);
   endtask

   initial begin : monitor
      exp_t e;
      exp_t got;
      string tag;
      forever begin
         @(vec_ev);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = '{aluout: bus.aluout, wb_data: bus.wb_data, reg_dst: bus.reg_dst,
                    reg_write: bus.reg_write, apb_op: bus.apb_op, apb_write: bus.apb_write,
                    continue_flag: bus.continue_flag, nia: bus.nia, br: bus.br};
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL %s: got alu=%h wb=%h dst=%b rw=%b apb=%b apbw=%b cont=%b nia=%b br=%b expected alu=%h wb=%h dst=%b rw=%b apb=%b apbw=%b cont=%b nia=%b br=%b",
                        tag, got.aluout, got.wb_data, got.reg_dst, got.reg_write, got.apb_op,
                        got.apb_write, got.continue_flag, got.nia, got.br, e.aluout,
                        e.wb_data, e.reg_dst, e.reg_write, e.apb_op, e.apb_write,
                        e.continue_flag, e.nia, e.br);
            end
         end
      end
   end

   initial begin : driver
      logic [3:0] op;
      bus.opcode = 4'hF;
      bus.func   = 3'd0;
      bus.ready  = 1'b0;
      bus.ra     = 8'h00;
      bus.rb     = 8'h00;
      bus.imm    = 8'h00;
      foreach (ref_mem[i]) ref_mem[i] = 8'hXX;
      set_rst(1'b0);
      apply("reset_load", 4'h4, 3'd0, 1'b1, 8'h37, 8'h00, 8'h02);
      apply("reset_nop", 4'hF, 3'd0, 1'b1, 8'h01, 8'h02, 8'h03);
      set_rst(1'b1);

      apply("rtype_sub", 4'h0, 3'd1, 1'b1, 8'hF0, 8'h20, 8'h00);
      apply("store", 4'h5, 3'd0, 1'b1, 8'h10, 8'hAB, 8'h05);
      apply("load_after_store", 4'h4, 3'd0, 1'b1, 8'h15, 8'h00, 8'h00);
      apply("beq_eq", 4'h6, 3'd0, 1'b1, 8'h33, 8'h33, 8'h00);
      apply("beq_ne", 4'h6, 3'd0, 1'b1, 8'h33, 8'h34, 8'h00);
      apply("bne_eq", 4'h7, 3'd0, 1'b1, 8'h33, 8'h33, 8'h00);
      apply("bne_ne", 4'h7, 3'd0, 1'b1, 8'h33, 8'h34, 8'h00);
      apply("rtype_sub_eq", 4'h0, 3'd1, 1'b1, 8'h33, 8'h33, 8'h00);
      apply("jump", 4'h8, 3'd0, 1'b1, 8'h12, 8'h34, 8'h56);
      apply("nop", 4'hF, 3'd0, 1'b1, 8'h12, 8'h34, 8'h56);
      apply("apb_rd_stall", 4'hA, 3'd0, 1'b0, 8'h12, 8'h34, 8'h56);
      apply("apb_rd_done", 4'hA, 3'd0, 1'b1, 8'h12, 8'h34, 8'h56);
      apply("apb_wr_done", 4'h9, 3'd0, 1'b1, 8'h12, 8'h34, 8'h56);
      apply("apb_wr_stall", 4'h9, 3'd0, 1'b0, 8'h12, 8'h34, 8'h56);

      apply("store_5a", 4'h5, 3'd0, 1'b1, 8'h20, 8'h5A, 8'h00);
      apply("load_5a", 4'h4, 3'd0, 1'b1, 8'h20, 8'h00, 8'h00);
      apply("load_5a_again", 4'h4, 3'd0, 1'b1, 8'h1F, 8'h00, 8'h01);
      pulse_rst();
      apply("load_after_rst", 4'h4, 3'd0, 1'b1, 8'h20, 8'h00, 8'h00);
      apply("store_77", 4'h5, 3'd0, 1'b1, 8'h30, 8'h77, 8'h00);
      set_rst(1'b0);
      apply("apb_stall_in_rst", 4'hA, 3'd0, 1'b0, 8'h30, 8'h00, 8'h00);
      apply("store_in_rst", 4'h5, 3'd0, 1'b1, 8'h30, 8'h99, 8'h00);
      apply("load_in_rst", 4'h4, 3'd0, 1'b1, 8'h30, 8'h00, 8'h00);
      set_rst(1'b1);
      apply("load_blocked_store", 4'h4, 3'd0, 1'b1, 8'h30, 8'h00, 8'h00);
      apply("store_first_edge", 4'h5, 3'd0, 1'b1, 8'h31, 8'hC3, 8'h00);
      apply("load_first_edge", 4'h4, 3'd0, 1'b1, 8'h31, 8'h00, 8'h00);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) != 0) ? 4'h4 : 4'h5;
         else op = 4'($urandom_range(0, 15));
         apply("random", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom),
               ($urandom_range(0, 3) == 0) ? bus.ra : 8'($urandom),
               ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom));
         if ($urandom_range(0, 49) == 0) pulse_rst();
      end

      #3;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
